// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch hazard controller: one-cycle load-use stall for branch operands,
// taken-branch redirect/flush, and saturating stall/taken counters for debug.
module branch_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_id_branch,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_mem_read,
  input  logic             equal_in,
  input  logic             ext_hold,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             pc_src,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  // state      | meaning
  // IDLE       | normal flow, hazard check active
  // LOAD_STALL | bubble issued, load now in MEM, branch resolves this cycle
  localparam logic [1:0] IDLE       = 2'b00;
  localparam logic [1:0] LOAD_STALL = 2'b01;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0] state, state_nxt;
  logic       hazard, taken, stall_inc, taken_inc;

  assign hazard = if_id_branch & id_ex_mem_read & (id_ex_rd != 5'd0) &
                  ((id_ex_rd == if_id_rs) | (id_ex_rd == if_id_rt));
  assign taken  = if_id_branch & equal_in;

  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    pc_src       = 1'b0;
    state_nxt    = state;
    stall_inc    = 1'b0;
    taken_inc    = 1'b0;
    if (reset) begin
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
      state_nxt    = IDLE;
    end else if (!ext_hold) begin
      case (state)
        LOAD_STALL: begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
          pc_src      = taken;
          if_id_flush = taken;
          taken_inc   = taken;
          state_nxt   = IDLE;
        end
        // IDLE and any undefined encoding behave as IDLE, which also recovers the state
        default: begin
          if (hazard) begin
            id_ex_bubble = 1'b1;
            stall_inc    = 1'b1;
            state_nxt    = LOAD_STALL;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            pc_src      = taken;
            if_id_flush = taken;
            taken_inc   = taken;
            state_nxt   = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      stall_cnt <= '0;
      taken_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (stall_inc && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (taken_inc && (taken_cnt != CNT_MAX)) taken_cnt <= taken_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Bench for branch_hazard_ctrl: directed hazard scenarios plus random traffic,
// checked every cycle against a behavioural model (16-bit and 2-bit counter builds).
module tb_branch_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, if_id_branch, id_ex_mem_read, equal_in, ext_hold;
  logic [4:0] if_id_rs, if_id_rt, id_ex_rd;

  logic        pc_write, if_id_write, id_ex_bubble, if_id_flush, pc_src;
  logic [15:0] stall_cnt, taken_cnt;
  logic        s_pc_write, s_if_id_write, s_id_ex_bubble, s_if_id_flush, s_pc_src;
  logic [1:0]  s_stall_cnt, s_taken_cnt;

  branch_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .if_id_branch(if_id_branch), .if_id_rs(if_id_rs),
    .if_id_rt(if_id_rt), .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
    .equal_in(equal_in), .ext_hold(ext_hold), .pc_write(pc_write),
    .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
    .pc_src(pc_src), .stall_cnt(stall_cnt), .taken_cnt(taken_cnt)
  );

  branch_hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .if_id_branch(if_id_branch), .if_id_rs(if_id_rs),
    .if_id_rt(if_id_rt), .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
    .equal_in(equal_in), .ext_hold(ext_hold), .pc_write(s_pc_write),
    .if_id_write(s_if_id_write), .id_ex_bubble(s_id_ex_bubble), .if_id_flush(s_if_id_flush),
    .pc_src(s_pc_src), .stall_cnt(s_stall_cnt), .taken_cnt(s_taken_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // model: are we in the cycle after a detected load-use hazard, plus counter values
  bit m_stalled = 1'b0;
  int m_stall = 0, m_taken = 0, ms_stall = 0, ms_taken = 0;

  function automatic int sat_inc(input int v, input int max);
    return (v < max) ? v + 1 : v;
  endfunction

  task automatic cyc(input bit rst, input bit hold, input bit br, input bit mr,
                     input bit eq, input int rs, input int rt, input int rd);
    bit haz, tk;
    logic [4:0] exp_o;
    reset = rst; ext_hold = hold; if_id_branch = br; id_ex_mem_read = mr;
    equal_in = eq; if_id_rs = 5'(rs); if_id_rt = 5'(rt); id_ex_rd = 5'(rd);
    haz = br && mr && (rd != 0) && (rd == rs || rd == rt);
    tk  = br && eq;
    @(negedge clk);
    // exp_o = {pc_write, if_id_write, id_ex_bubble, if_id_flush, pc_src}
    if (rst)                    exp_o = 5'b00110;
    else if (hold)              exp_o = 5'b00000;
    else if (!m_stalled && haz) exp_o = 5'b00100;
    else                        exp_o = {2'b11, 1'b0, tk, tk};
    check_val("ctrl", {pc_write, if_id_write, id_ex_bubble, if_id_flush, pc_src}, exp_o);
    check_val("ctrl_w2", {s_pc_write, s_if_id_write, s_id_ex_bubble, s_if_id_flush, s_pc_src}, exp_o);
    check_val("stall_cnt", stall_cnt, m_stall);
    check_val("taken_cnt", taken_cnt, m_taken);
    check_val("stall_cnt_w2", s_stall_cnt, ms_stall);
    check_val("taken_cnt_w2", s_taken_cnt, ms_taken);
    if (rst) begin
      m_stalled = 0; m_stall = 0; m_taken = 0; ms_stall = 0; ms_taken = 0;
    end else if (!hold) begin
      if (!m_stalled && haz) begin
        m_stalled = 1;
        m_stall  = sat_inc(m_stall, 65535);
        ms_stall = sat_inc(ms_stall, 3);
      end else begin
        m_stalled = 0;
        if (tk) begin
          m_taken  = sat_inc(m_taken, 65535);
          ms_taken = sat_inc(ms_taken, 3);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset, then idle
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // load-use then taken
    cyc(0, 0, 1, 1, 0, 5, 6, 5);
    cyc(0, 0, 1, 0, 1, 5, 6, 0);
    check_val("lu_stall_cnt", stall_cnt, 32'd1);
    check_val("lu_taken_cnt", taken_cnt, 32'd1);

    // ALU producer: no stall
    cyc(0, 0, 1, 0, 0, 7, 3, 7);
    check_val("alu_stall_cnt", stall_cnt, 32'd1);

    // r0 load destination: no stall, taken immediately
    cyc(0, 0, 1, 1, 1, 0, 0, 0);

    // hold during stall
    cyc(0, 0, 1, 1, 0, 5, 6, 5);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1, 0, 5, 6, 5);
    cyc(0, 0, 1, 0, 1, 5, 6, 0);
    check_val("hold_stall_cnt", stall_cnt, 32'd2);

    // saturation on the 2-bit build
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 1, 1, 2, 3);
    check_val("sat_taken_w2", s_taken_cnt, 32'd3);
    check_val("sat_taken", taken_cnt, 32'd5);

    // reset mid-stall abandons the stall
    cyc(0, 0, 1, 1, 0, 4, 4, 4);
    cyc(1, 0, 1, 0, 1, 4, 4, 0);
    check_val("rst_stall_cnt", stall_cnt, 32'd0);
    cyc(0, 0, 1, 1, 0, 4, 2, 4);

    for (int i = 0; i < 3000; i++)
      cyc(($urandom % 50) == 0, ($urandom % 5) == 0, $urandom % 2, $urandom % 2,
          $urandom % 2, $urandom % 4, $urandom % 4, $urandom % 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
